// File: rtl/cond_logic_unit.sv
// Condition-check and write-gating unit for ALU flags, with sequencing for a multi-cycle execute unit.
// Optional macro COND_NV_TRAP_EN: when defined, Cond==4'b1111 in IDLE raises Undef on the next cycle.
module cond_logic_unit #(
    parameter logic [3:0] FLAG_RST = 4'b0000,
    parameter int         WAIT_MAX = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       pcs_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    input  logic       no_write_i,
    input  logic       mstart_i,
    input  logic       mbusy_i,
    output logic       pc_src_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       cond_ex_o,
    output logic       stall_o,
    output logic       timeout_o,
    output logic       undef_o,
    output logic [3:0] flags_o
);
    localparam int CW = $clog2(WAIT_MAX);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t         state_q, state_d;
    logic [3:0]     flags_q, flags_d;
    logic [CW-1:0]  count_q, count_d;
    logic           preg_w_q, preg_w_d;
    logic [1:0]     pflag_w_q, pflag_w_d;
    logic           n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        case (cond_i)
            4'b0000: cond_ex_o = z;
            4'b0001: cond_ex_o = ~z;
            4'b0010: cond_ex_o = c;
            4'b0011: cond_ex_o = ~c;
            4'b0100: cond_ex_o = n;
            4'b0101: cond_ex_o = ~n;
            4'b0110: cond_ex_o = v;
            4'b0111: cond_ex_o = ~v;
            4'b1000: cond_ex_o = c & ~z;
            4'b1001: cond_ex_o = ~c | z;
            4'b1010: cond_ex_o = (n == v);
            4'b1011: cond_ex_o = (n != v);
            4'b1100: cond_ex_o = ~z & (n == v);
            4'b1101: cond_ex_o = z | (n != v);
            4'b1110: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        count_d     = count_q;
        preg_w_d    = preg_w_q;
        pflag_w_d   = pflag_w_q;
        pc_src_o    = 1'b0;
        reg_write_o = 1'b0;
        mem_write_o = 1'b0;
        stall_o     = 1'b0;
        timeout_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!mstart_i) begin
                    pc_src_o    = pcs_i & cond_ex_o;
                    reg_write_o = reg_w_i & ~no_write_i & cond_ex_o;
                    mem_write_o = mem_w_i & cond_ex_o;
                    if (cond_ex_o) begin
                        if (flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
                        if (flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
                    end
                end else if (cond_ex_o) begin
                    // Writeback and flag commit are deferred until the unit reports done.
                    preg_w_d  = reg_w_i & ~no_write_i;
                    pflag_w_d = flag_w_i;
                    count_d   = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (!mbusy_i) begin
                    reg_write_o = preg_w_q;
                    if (pflag_w_q[1]) flags_d[3:2] = alu_flags_i[3:2];
                    if (pflag_w_q[0]) flags_d[1:0] = alu_flags_i[1:0];
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(WAIT_MAX - 1)) begin
                        timeout_o = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            flags_q   <= FLAG_RST;
            count_q   <= '0;
            preg_w_q  <= 1'b0;
            pflag_w_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            count_q   <= count_d;
            preg_w_q  <= preg_w_d;
            pflag_w_q <= pflag_w_d;
        end
    end

    assign flags_o = flags_q;

`ifdef COND_NV_TRAP_EN
    logic undef_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) undef_q <= 1'b0;
        else         undef_q <= (state_q == S_IDLE) && (cond_i == 4'b1111);
    end
    assign undef_o = undef_q;
`else
    assign undef_o = 1'b0;
`endif

endmodule
